uart_sram_loader: RTL and testbench



---
 rtl/loader_pkg.sv | 7 +
 rtl/uart_rx.sv | 78 +++++++
 rtl/uart_sram_loader.sv | 113 +++++++++++
 tb/tb_uart_sram_loader.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// loader_pkg: shared types and constants for the UART-to-SRAM framebuffer loader.
package loader_pkg;
  localparam int DEF_CLK_DIV = 938;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  typedef enum logic [2:0] {P_SYNC, P_A2, P_A1, P_A0, P_L1, P_L0, P_DLO, P_DHI} pstate_e;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rstate_e;
endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with 2-flop synchroniser and centre sampling.
module uart_rx
  import loader_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       stop_err
);
  localparam int CW = $clog2(CLK_DIV);
  logic s1_q, s2_q, s3_q;
  rstate_e st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic vld_q, vld_d, err_q, err_d;
  logic full, half;
  assign full = cnt_q == CW'(CLK_DIV - 1);
  assign half = cnt_q == CW'(CLK_DIV / 2 - 1);
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q + 1'b1;
    bit_d = bit_q;
    sh_d = sh_q;
    vld_d = 1'b0;
    err_d = 1'b0;
    case (st_q)
      R_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        st_d = (s3_q && !s2_q) ? R_START : R_IDLE;
      end
      R_START: if (half) begin
        cnt_d = '0;
        st_d = s2_q ? R_IDLE : R_DATA;
      end
      R_DATA: if (full) begin
        cnt_d = '0;
        sh_d = {s2_q, sh_q[7:1]};
        bit_d = bit_q + 3'd1;
        st_d = (bit_q == 3'd7) ? R_STOP : R_DATA;
      end
      R_STOP: if (full) begin
        st_d = R_IDLE;
        vld_d = s2_q;
        err_d = !s2_q;
      end
      default: st_d = R_IDLE;
    endcase
  end
  // s3_q is the previous synchronised sample, used only for falling-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {s1_q, s2_q, s3_q} <= 3'b111;
      st_q <= R_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      vld_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      {s1_q, s2_q, s3_q} <= {rxd, s1_q, s2_q};
      st_q <= st_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      vld_q <= vld_d;
      err_q <= err_d;
    end
  end
  assign byte_valid = vld_q;
  assign byte_data = sh_q;
  assign stop_err = err_q;
endmodule

// File: rtl/uart_sram_loader.sv
// uart_sram_loader: parses framed UART packets into 16-bit SRAM word write requests.
module uart_sram_loader
  import loader_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int ADDR_W  = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxd,
  output logic              wr_req,
  input  logic              wr_ack,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun
);
  logic bv, se, sync_ok;
  logic [7:0] bd;
  uart_rx #(.CLK_DIV(CLK_DIV)) u_rx (
    .clk(clk), .rst(rst), .rxd(rxd),
    .byte_valid(bv), .byte_data(bd), .stop_err(se)
  );
  pstate_e ps_q, ps_d;
  logic [ADDR_W-1:0] addr_q, addr_d, wa_q, wa_d;
  logic [15:0] len_q, len_d, wd_q, wd_d;
  logic [7:0] lo_q, lo_d;
  logic req_q, req_d, busy_q, busy_d, fe_q, fe_d, ov_q, ov_d;
  always_comb begin
    ps_d = ps_q;
    addr_d = addr_q;
    len_d = len_q;
    lo_d = lo_q;
    wa_d = wa_q;
    wd_d = wd_q;
    fe_d = fe_q;
    ov_d = ov_q;
    req_d = req_q && !wr_ack;
    sync_ok = 1'b0;
    if (se) begin
      ps_d = P_SYNC;
      fe_d = 1'b1;
    end else if (bv) begin
      case (ps_q)
        P_SYNC: if (bd == SYNC_BYTE) begin
          ps_d = P_A2;
          sync_ok = 1'b1;
        end
        // address bytes shift in; bits above ADDR_W fall off the top
        P_A2, P_A1, P_A0: begin
          addr_d = ADDR_W'({addr_q, bd});
          ps_d = pstate_e'(ps_q + 3'd1);
        end
        P_L1: begin
          len_d = {len_q[7:0], bd};
          ps_d = P_L0;
        end
        P_L0: begin
          len_d = {len_q[7:0], bd};
          ps_d = ({len_q[7:0], bd} == 16'd0) ? P_SYNC : P_DLO;
        end
        P_DLO: begin
          lo_d = bd;
          ps_d = P_DHI;
        end
        P_DHI: begin
          // a same-cycle ack frees the holding register for the new word
          if (!req_d) begin
            wa_d = addr_q;
            wd_d = {bd, lo_q};
            req_d = 1'b1;
          end else ov_d = 1'b1;
          addr_d = addr_q + 1'b1;
          len_d = len_q - 16'd1;
          ps_d = (len_q == 16'd1) ? P_SYNC : P_DLO;
        end
      endcase
    end
    busy_d = sync_ok ? 1'b1 : (se || (ps_d == P_SYNC && !req_d)) ? 1'b0 : busy_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_q <= P_SYNC;
      addr_q <= '0;
      len_q <= '0;
      lo_q <= '0;
      wa_q <= '0;
      wd_q <= '0;
      req_q <= 1'b0;
      busy_q <= 1'b0;
      fe_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      ps_q <= ps_d;
      addr_q <= addr_d;
      len_q <= len_d;
      lo_q <= lo_d;
      wa_q <= wa_d;
      wd_q <= wd_d;
      req_q <= req_d;
      busy_q <= busy_d;
      fe_q <= fe_d;
      ov_q <= ov_d;
    end
  end
  assign wr_req = req_q;
  assign wr_addr = wa_q;
  assign wr_data = wd_q;
  assign busy = busy_q;
  assign frame_err = fe_q;
  assign overrun = ov_q;
endmodule

// File: tb/tb_uart_sram_loader.sv
// tb_uart_sram_loader: scoreboard bench driving UART packets and auto-acking SRAM writes.
module tb_uart_sram_loader;
  localparam int DIV = 8;
  localparam int AW = 18;
  typedef struct packed {logic [AW-1:0] a; logic [15:0] d;} wr_t;
  typedef logic [7:0] bq_t[$];
  logic clk = 1'b0, rst = 1'b1, rxd = 1'b1, wr_ack = 1'b0;
  logic wr_req, busy, frame_err, overrun;
  logic [AW-1:0] wr_addr;
  logic [15:0] wr_data;
  int vectors = 0, miscompares = 0;
  int ack_dly = 3, ack_cnt = 0;
  logic ack_en = 1'b1;
  wr_t exp_q[$], got_q[$];
  wr_t e, g;

  uart_sram_loader #(.CLK_DIV(DIV), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .wr_req(wr_req), .wr_ack(wr_ack),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // SRAM owner model: acks ack_dly cycles after seeing a request and logs the committed word
  initial begin
    forever begin
      @(negedge clk);
      wr_ack = 1'b0;
      if (ack_en && wr_req && !rst) begin
        if (ack_cnt >= ack_dly) begin
          wr_ack = 1'b1;
          got_q.push_back(wr_t'{wr_addr, wr_data});
          ack_cnt = 0;
        end else ack_cnt++;
      end else ack_cnt = 0;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
    rxd = stop;
    repeat (DIV) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic send_bytes(input bq_t q);
    foreach (q[i]) send_byte(q[i]);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_idle(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = !busy && !wr_req;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({wr_req, wr_addr, wr_data, busy, frame_err, overrun} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got req=%b addr=%h data=%h busy=%b fe=%b ov=%b, expected all 0",
               wr_req, wr_addr, wr_data, busy, frame_err, overrun);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({wr_req, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_release: got req=%b busy=%b, expected 0 0", wr_req, busy);
    end
  endtask

  task automatic test_basic;
    logic ok;
    got_q.delete();
    exp_q.push_back(wr_t'{18'h00100, 16'h1234});
    exp_q.push_back(wr_t'{18'h00101, 16'h5678});
    send_bytes('{8'hA5});
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_busy_rise: got %b, expected 1", busy);
    end
    send_bytes('{8'h00, 8'h01, 8'h00, 8'h00, 8'h02, 8'h34, 8'h12, 8'h78, 8'h56});
    wait_idle(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL basic_idle: busy=%b req=%b, expected both 0 within bound", busy, wr_req);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (got_q.size() == 0) begin
        miscompares++;
        $display("FAIL basic_wr: got no write, expected %05h=%04h", e.a, e.d);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin
          miscompares++;
          $display("FAIL basic_wr: got %05h=%04h, expected %05h=%04h", g.a, g.d, e.a, e.d);
        end
      end
    end
    vectors++;
    if (got_q.size() != 0 || frame_err || overrun) begin
      miscompares++;
      $display("FAIL basic_extra: got %0d extra writes fe=%b ov=%b, expected 0 0 0",
               got_q.size(), frame_err, overrun);
    end
  endtask

  task automatic test_wrap;
    logic ok;
    got_q.delete();
    exp_q.push_back(wr_t'{18'h3FFFF, 16'h2211});
    exp_q.push_back(wr_t'{18'h00000, 16'h4433});
    send_bytes('{8'hA5, 8'h03, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44});
    wait_idle(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL wrap_idle: busy=%b req=%b, expected both 0 within bound", busy, wr_req);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (got_q.size() == 0) begin
        miscompares++;
        $display("FAIL wrap_wr: got no write, expected %05h=%04h", e.a, e.d);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin
          miscompares++;
          $display("FAIL wrap_wr: got %05h=%04h, expected %05h=%04h", g.a, g.d, e.a, e.d);
        end
      end
    end
  endtask

  task automatic test_garbage;
    got_q.delete();
    send_bytes('{8'h00, 8'hFF, 8'h5A});
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL garbage_busy: got %b, expected 0", busy);
    end
    send_bytes('{8'hA5});
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL garbage_sync_busy: got %b, expected 1", busy);
    end
    send_bytes('{8'h00, 8'h00, 8'h10, 8'h00, 8'h00});
    vectors++;
    if ({busy, wr_req, frame_err, overrun} !== 4'b0000 || got_q.size() != 0) begin
      miscompares++;
      $display("FAIL garbage_len0: got busy=%b req=%b fe=%b ov=%b writes=%0d, expected all 0",
               busy, wr_req, frame_err, overrun, got_q.size());
    end
  endtask

  task automatic test_frame_err;
    logic ok;
    got_q.delete();
    send_bytes('{8'hA5, 8'h00, 8'h02});
    send_byte(8'h00, 1'b0);
    repeat (2 * DIV) @(negedge clk);
    vectors++;
    if ({frame_err, busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL frame_err_flag: got fe=%b busy=%b, expected 1 0", frame_err, busy);
    end
    exp_q.push_back(wr_t'{18'h00200, 16'hABCD});
    send_bytes('{8'hA5, 8'h00, 8'h02, 8'h00, 8'h00, 8'h01, 8'hCD, 8'hAB});
    wait_idle(ok);
    e = exp_q.pop_front();
    vectors++;
    if (!ok || got_q.size() != 1) begin
      miscompares++;
      $display("FAIL frame_err_next: got %0d writes idle=%b, expected 1 write idle=1", got_q.size(), ok);
    end else begin
      g = got_q.pop_front();
      if (g !== e) begin
        miscompares++;
        $display("FAIL frame_err_next: got %05h=%04h, expected %05h=%04h", g.a, g.d, e.a, e.d);
      end
    end
    vectors++;
    if (frame_err !== 1'b1) begin
      miscompares++;
      $display("FAIL frame_err_sticky: got %b, expected 1", frame_err);
    end
  endtask

  task automatic test_overrun;
    logic ok;
    got_q.delete();
    ack_en = 1'b0;
    exp_q.push_back(wr_t'{18'h00300, 16'hB0A0});
    exp_q.push_back(wr_t'{18'h00302, 16'hB2A2});
    send_bytes('{8'hA5, 8'h00, 8'h03, 8'h00, 8'h00, 8'h03, 8'hA0, 8'hB0});
    vectors++;
    if ({wr_req, wr_addr, wr_data, overrun} !== {1'b1, 18'h00300, 16'hB0A0, 1'b0}) begin
      miscompares++;
      $display("FAIL overrun_first: got req=%b %05h=%04h ov=%b, expected 1 00300=b0a0 0",
               wr_req, wr_addr, wr_data, overrun);
    end
    send_bytes('{8'hA1, 8'hB1});
    vectors++;
    if ({wr_req, wr_addr, wr_data, overrun} !== {1'b1, 18'h00300, 16'hB0A0, 1'b1}) begin
      miscompares++;
      $display("FAIL overrun_hold: got req=%b %05h=%04h ov=%b, expected 1 00300=b0a0 1",
               wr_req, wr_addr, wr_data, overrun);
    end
    ack_en = 1'b1;
    send_bytes('{8'hA2, 8'hB2});
    wait_idle(ok);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (got_q.size() == 0) begin
        miscompares++;
        $display("FAIL overrun_wr: got no write, expected %05h=%04h", e.a, e.d);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin
          miscompares++;
          $display("FAIL overrun_wr: got %05h=%04h, expected %05h=%04h", g.a, g.d, e.a, e.d);
        end
      end
    end
    vectors++;
    if (!ok || got_q.size() != 0) begin
      miscompares++;
      $display("FAIL overrun_end: idle=%b extra=%0d, expected 1 0", ok, got_q.size());
    end
  endtask

  task automatic test_rst_mid;
    logic ok;
    got_q.delete();
    ack_en = 1'b0;
    send_bytes('{8'hA5, 8'h00, 8'h04, 8'h00, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33});
    vectors++;
    if ({wr_req, busy} !== 2'b11) begin
      miscompares++;
      $display("FAIL rst_mid_pre: got req=%b busy=%b, expected 1 1", wr_req, busy);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({wr_req, wr_addr, wr_data, busy, frame_err, overrun} !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: got req=%b addr=%h data=%h busy=%b fe=%b ov=%b, expected all 0",
               wr_req, wr_addr, wr_data, busy, frame_err, overrun);
    end
    @(negedge clk);
    rst = 1'b0;
    ack_en = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    exp_q.push_back(wr_t'{18'h00500, 16'hBEEF});
    send_bytes('{8'hA5, 8'h00, 8'h05, 8'h00, 8'h00, 8'h01, 8'hEF, 8'hBE});
    wait_idle(ok);
    e = exp_q.pop_front();
    vectors++;
    if (!ok || got_q.size() != 1) begin
      miscompares++;
      $display("FAIL rst_mid_next: got %0d writes idle=%b, expected 1 write idle=1", got_q.size(), ok);
    end else begin
      g = got_q.pop_front();
      if (g !== e) begin
        miscompares++;
        $display("FAIL rst_mid_next: got %05h=%04h, expected %05h=%04h", g.a, g.d, e.a, e.d);
      end
    end
    vectors++;
    if ({frame_err, overrun} !== 2'b00) begin
      miscompares++;
      $display("FAIL rst_mid_flags: got fe=%b ov=%b, expected 0 0", frame_err, overrun);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_garbage();
    test_frame_err();
    test_overrun();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
